tpu_result_streamer: RTL
========================

Name: tpu_result_streamer

Overview:
Read-side counterpart of the TPU memory loader. Once the systolic array has written the 4x4 result matrix into feature memory at addresses 16..31, this block reads it back and transmits it row-major on port_O, one element per valid/ready handshake. It sits between the feature memory read port and the TPU output pins, and replaces ad-hoc hierarchical peeks into Feature_Memory.

Parameters:
DATA_W, 8, element width (matches port_A/port_W/port_O)
ADDR_W, 5, feature memory address width (32 entries)
BASE_ADDR, 16, address of result element [0][0]
NUM_ELEMS, 16, elements per result matrix (4x4)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to stream the result matrix; honoured only in IDLE
mem_rd_en  out  1  feature memory read strobe
mem_rd_addr  out  ADDR_W  feature memory read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
port_O  out  DATA_W  output element
out_valid  out  1  port_O holds a valid element
out_ready  in  1  downstream accepts element when high with out_valid
out_last  out  1  high with out_valid for element NUM_ELEMS-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last element accepted

Behaviour:
- Reset (async assert, any state): state=IDLE, idx=0, port_O=0, out_valid=0, out_last=0, mem_rd_en=0, mem_rd_addr=0, busy=0, done=0. Reset mid-stream abandons the transfer; no done pulse.
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE: start=1 -> FETCH, idx=0. start in any other state is ignored (not queued).
- FETCH: mem_rd_en=1, mem_rd_addr=BASE_ADDR+idx; -> LOAD.
- LOAD: mem_rd_en=0; at cycle end port_O<=mem_rd_data, out_valid<=1, out_last<=(idx==NUM_ELEMS-1); -> SEND.
- SEND: port_O, out_valid, out_last held stable while out_ready=0 (no timeout). On out_valid&&out_ready: out_valid<=0, out_last<=0; if idx==NUM_ELEMS-1 -> DONE else idx<=idx+1, -> FETCH.
- DONE: done=1 for exactly one cycle; -> IDLE. port_O keeps last value (not cleared).
- mem_rd_en/mem_rd_addr registered outputs decoded from state; mem_rd_addr holds last value outside FETCH.
- Latency: start sampled in cycle 0; element k valid from cycle 3+3k with out_ready held high; last element in cycle 48, done in cycle 49, IDLE (start accepted again) in cycle 50.
- idx is ceil(log2(NUM_ELEMS)) bits; address add is ADDR_W wide, BASE_ADDR+NUM_ELEMS-1 must fit (checked by elaboration-time guard).
- No data transformation: port_O is the memory byte unchanged (quantization already applied upstream).

Decomposition:
- Shared header tpu_defs.vh: state encodings (IDLE=0..DONE=4), RESULT_BASE_ADDR=16, MATRIX_ELEMS=16, DATA_W=8; also used by loader and TPU top.
- No sub-module; FSM, index counter and output register stay in one module.

Test Plan:
- Memory model preloaded addr16..31 = 40,27,14,8 repeated x4; start pulse, out_ready=1 -> port_O sequence 40,27,14,8 x4, out_last only on 16th, done in cycle 49.
- Addr check: preload addr n = n (16..31) -> mem_rd_addr 16..31 in order, port_O = 16..31, no reads outside range.
- Backpressure: out_ready low 5 cycles on element 3 -> port_O/out_valid/out_last stable throughout, element 4 not fetched until accept, sequence intact.
- start re-pulsed during SEND of element 7 -> ignored: exactly 16 elements, one done pulse; start in cycle 50 -> second full stream.
- Async rst asserted mid-LOAD of element 9 -> all outputs 0 immediately (before next edge), no done; subsequent start streams from addr16.
- No start after reset for 100 cycles -> mem_rd_en, out_valid, busy, done stay 0.

Source files
------------

// File: rtl/tpu_result_streamer_pkg.sv
// Shared TPU result-matrix definitions: FSM state encoding and matrix placement in feature memory.
package tpu_result_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int RESULT_DATA_W    = 8;
    localparam int RESULT_ADDR_W    = 5;
    localparam int RESULT_BASE_ADDR = 16;
    localparam int MATRIX_ELEMS     = 16;

endpackage

// File: rtl/tpu_result_streamer.sv
// Reads the 4x4 result matrix back from feature memory and streams it row-major
// on port_O with a valid/ready handshake, one element per fetch/load/send round.
module tpu_result_streamer
    import tpu_result_streamer_pkg::*;
#(
    parameter int DATA_W    = RESULT_DATA_W,
    parameter int ADDR_W    = RESULT_ADDR_W,
    parameter int BASE_ADDR = RESULT_BASE_ADDR,
    parameter int NUM_ELEMS = MATRIX_ELEMS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] port_O,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    // The whole matrix must be addressable without the address add wrapping.
    if (BASE_ADDR + NUM_ELEMS - 1 > (1 << ADDR_W) - 1) begin : g_addr_range_guard
        $error("tpu_result_streamer: BASE_ADDR+NUM_ELEMS-1 exceeds ADDR_W address space");
    end

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   port_d;
    logic                valid_d, last_d;
    logic                rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        port_d    = port_O;
        valid_d   = out_valid;
        last_d    = out_last;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                port_d  = mem_rd_data;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST_IDX);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Read strobe is registered so it lines up with the cycle spent in FETCH.
        rd_en_d   = (state_d == ST_FETCH);
        rd_addr_d = rd_en_d ? (ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d)) : mem_rd_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            port_O      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            port_O      <= port_d;
            out_valid   <= valid_d;
            out_last    <= last_d;
            mem_rd_en   <= rd_en_d;
            mem_rd_addr <= rd_addr_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule
